// File: rtl/iiitb_wm_pkg.sv
// iiitb_wm_pkg: shared definitions for the washing-machine controller.
//   - 4-bit state codes (reported on state_o)
//   - wash-mode codes and wash-phase values
//   - actuator/status bundle and its Moore decode from a state code
package iiitb_wm_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FILL      = 4'd1;
    localparam logic [3:0] ST_DETERGENT = 4'd2;
    localparam logic [3:0] ST_AGITATE   = 4'd3;
    localparam logic [3:0] ST_DRAIN     = 4'd4;
    localparam logic [3:0] ST_SPIN      = 4'd5;
    localparam logic [3:0] ST_DONE      = 4'd6;
    localparam logic [3:0] ST_PAUSE     = 4'd7;
    localparam logic [3:0] ST_FAULT     = 4'd8;

    localparam logic [1:0] MODE_QUICK  = 2'd0;
    localparam logic [1:0] MODE_NORMAL = 2'd1;
    localparam logic [1:0] MODE_HEAVY  = 2'd2;
    localparam logic [1:0] MODE_RINSE  = 2'd3;

    localparam logic PHASE_SOAP  = 1'b0;
    localparam logic PHASE_RINSE = 1'b1;

    typedef struct packed {
        logic door_lock;
        logic motor_on;
        logic motor_fast;
        logic fill_valve_on;
        logic drain_valve_on;
        logic detergent_req;
        logic done;
        logic fault;
        logic busy;
    } act_t;

    // Moore output decode; an unknown code is treated like FAULT (door stays locked).
    function automatic act_t decode_state(input logic [3:0] st);
        act_t a;
        a = '0;
        case (st)
            ST_IDLE:      a = '0;
            ST_FILL:      begin a.door_lock = 1'b1; a.fill_valve_on = 1'b1; a.busy = 1'b1; end
            ST_DETERGENT: begin a.door_lock = 1'b1; a.detergent_req = 1'b1; a.busy = 1'b1; end
            ST_AGITATE:   begin a.door_lock = 1'b1; a.motor_on = 1'b1; a.busy = 1'b1; end
            ST_DRAIN:     begin a.door_lock = 1'b1; a.drain_valve_on = 1'b1; a.busy = 1'b1; end
            ST_SPIN:      begin
                              a.door_lock = 1'b1; a.motor_on = 1'b1; a.motor_fast = 1'b1;
                              a.drain_valve_on = 1'b1; a.busy = 1'b1;
                          end
            ST_DONE:      a.done = 1'b1;
            ST_PAUSE:     begin a.door_lock = 1'b1; a.busy = 1'b1; end
            ST_FAULT:     begin a.door_lock = 1'b1; a.fault = 1'b1; end
            default:      begin a.door_lock = 1'b1; a.fault = 1'b1; end
        endcase
        return a;
    endfunction

endpackage

// File: rtl/iiitb_wm_timer.sv
// iiitb_wm_timer: loadable down-counter that advances only on tick.
//   clk, reset_n : clock, synchronous active-low reset
//   load, value  : load count with value (wins over tick on the same edge)
//   tick         : timebase strobe
//   hold         : freeze the count (pause)
//   expire       : high on the tick that takes the count from 1 to 0
module iiitb_wm_timer #(
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    input  logic               tick,
    input  logic               hold,
    output logic               expire
);

    logic [TIMER_W-1:0] count_r;

    // Count register: load on state entry, otherwise decrement on unheld ticks down to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= value;
        end else if (tick && !hold && (count_r != '0)) begin
            count_r <= count_r - TIMER_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // A load of N therefore expires on the Nth tick after the loading edge.
    assign expire = tick & ~hold & (count_r == TIMER_W'(1));

endmodule

// File: rtl/iiitb_wm_ctrl.sv
// iiitb_wm_ctrl: washing-machine program sequencer.
//   Inputs : clk, reset_n (sync, active-low), tick, start, door_closed, mode[1:0],
//            rinse_cnt[RINSE_W-1:0], filled, detergent_added, drained, pause, abort, fault_clr
//   Outputs: door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on, detergent_req,
//            done, fault, busy, state_o[3:0], rinse_left_o[RINSE_W-1:0]
// All outputs are registered copies of the decode of the next state, so they
// line up with state_o and have no combinational path from the inputs.
module iiitb_wm_ctrl
    import iiitb_wm_pkg::*;
#(
    parameter int TIMER_W       = 16,
    parameter int WASH_TICKS    = 100,
    parameter int RINSE_TICKS   = 50,
    parameter int SPIN_TICKS    = 80,
    parameter int FILL_TIMEOUT  = 200,
    parameter int DRAIN_TIMEOUT = 200,
    parameter int RINSE_W       = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               start,
    input  logic               door_closed,
    input  logic [1:0]         mode,
    input  logic [RINSE_W-1:0] rinse_cnt,
    input  logic               filled,
    input  logic               detergent_added,
    input  logic               drained,
    input  logic               pause,
    input  logic               abort,
    input  logic               fault_clr,
    output logic               door_lock,
    output logic               motor_on,
    output logic               motor_fast,
    output logic               fill_valve_on,
    output logic               drain_valve_on,
    output logic               detergent_req,
    output logic               done,
    output logic               fault,
    output logic               busy,
    output logic [3:0]         state_o,
    output logic [RINSE_W-1:0] rinse_left_o
);

    localparam logic [TIMER_W-1:0] WASH_V  = TIMER_W'(WASH_TICKS);
    localparam logic [TIMER_W-1:0] RINSE_V = TIMER_W'(RINSE_TICKS);
    localparam logic [TIMER_W-1:0] SPIN_V  = TIMER_W'(SPIN_TICKS);
    localparam logic [TIMER_W-1:0] FILL_V  = TIMER_W'(FILL_TIMEOUT);
    localparam logic [TIMER_W-1:0] DRAIN_V = TIMER_W'(DRAIN_TIMEOUT);

    logic [3:0]         state_r, state_s, saved_r, saved_s;
    logic               phase_r, phase_s, abort_r, abort_s;
    logic [1:0]         mode_r, mode_s;
    logic [RINSE_W-1:0] rinse_left_r, rinse_left_s;
    logic               load_s, hold_s, expire_s, pausable_s, engaged_s;
    logic [TIMER_W-1:0] load_val_s, agitate_val_s;
    act_t               act_r;

    assign pausable_s = (state_r == ST_FILL) || (state_r == ST_DETERGENT) || (state_r == ST_AGITATE)
                     || (state_r == ST_DRAIN) || (state_r == ST_SPIN);
    assign engaged_s  = pausable_s || (state_r == ST_PAUSE);
    // Freeze the timer while paused and on the edge that enters PAUSE, so an
    // expiry coinciding with pause is deferred to the first tick after resume.
    assign hold_s        = (state_r == ST_PAUSE) || (pausable_s && pause);
    assign agitate_val_s = (phase_r == PHASE_RINSE) ? RINSE_V : (WASH_V << mode_r);

    iiitb_wm_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .value   (load_val_s),
        .tick    (tick),
        .hold    (hold_s),
        .expire  (expire_s)
    );

    // Next-state logic in priority order: door fault, abort, pause, watchdog/normal.
    always_comb begin
        state_s      = state_r;
        saved_s      = saved_r;
        phase_s      = phase_r;
        abort_s      = abort_r;
        mode_s       = mode_r;
        rinse_left_s = rinse_left_r;
        load_s       = 1'b0;
        load_val_s   = '0;
        if (engaged_s && !door_closed) begin
            state_s = ST_FAULT;
        end else if (engaged_s && abort) begin
            abort_s    = 1'b1;
            state_s    = ST_DRAIN;
            load_s     = 1'b1;
            load_val_s = DRAIN_V;
        end else if (pausable_s && pause) begin
            saved_s = state_r;
            state_s = ST_PAUSE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && door_closed) begin
                        mode_s       = mode;
                        rinse_left_s = rinse_cnt;
                        phase_s      = (mode == MODE_RINSE) ? PHASE_RINSE : PHASE_SOAP;
                        state_s      = ST_FILL;
                        load_s       = 1'b1;
                        load_val_s   = FILL_V;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FILL: begin
                    if (expire_s) begin
                        state_s = ST_FAULT;
                    end else if (filled && (phase_r == PHASE_SOAP)) begin
                        state_s = ST_DETERGENT;
                    end else if (filled) begin
                        state_s    = ST_AGITATE;
                        load_s     = 1'b1;
                        load_val_s = agitate_val_s;
                    end else begin
                        state_s = ST_FILL;
                    end
                end
                ST_DETERGENT: begin
                    if (detergent_added) begin
                        state_s    = ST_AGITATE;
                        load_s     = 1'b1;
                        load_val_s = agitate_val_s;
                    end else begin
                        state_s = ST_DETERGENT;
                    end
                end
                ST_AGITATE: begin
                    if (expire_s) begin
                        state_s    = ST_DRAIN;
                        load_s     = 1'b1;
                        load_val_s = DRAIN_V;
                    end else begin
                        state_s = ST_AGITATE;
                    end
                end
                ST_DRAIN: begin
                    if (expire_s) begin
                        state_s = ST_FAULT;
                    end else if (drained && abort_r) begin
                        state_s = ST_DONE;
                    end else if (drained && (rinse_left_r != '0)) begin
                        rinse_left_s = rinse_left_r - RINSE_W'(1);
                        phase_s      = PHASE_RINSE;
                        state_s      = ST_FILL;
                        load_s       = 1'b1;
                        load_val_s   = FILL_V;
                    end else if (drained) begin
                        state_s    = ST_SPIN;
                        load_s     = 1'b1;
                        load_val_s = SPIN_V;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_SPIN: begin
                    if (expire_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SPIN;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    // Return without reloading; the timer resumes from its frozen count.
                    if (!pause) begin
                        state_s = saved_r;
                    end else begin
                        state_s = ST_PAUSE;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_s      = ST_IDLE;
                        abort_s      = 1'b0;
                        phase_s      = PHASE_SOAP;
                        rinse_left_s = '0;
                    end else begin
                        state_s = ST_FAULT;
                    end
                end
                default: begin
                    state_s = ST_FAULT;
                end
            endcase
        end
    end

    // Program state registers and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            saved_r      <= ST_IDLE;
            phase_r      <= PHASE_SOAP;
            abort_r      <= 1'b0;
            mode_r       <= MODE_QUICK;
            rinse_left_r <= '0;
            act_r        <= '0;
        end else begin
            state_r      <= state_s;
            saved_r      <= saved_s;
            phase_r      <= phase_s;
            abort_r      <= abort_s;
            mode_r       <= mode_s;
            rinse_left_r <= rinse_left_s;
            act_r        <= decode_state(state_s);
        end
    end

    assign door_lock      = act_r.door_lock;
    assign motor_on       = act_r.motor_on;
    assign motor_fast     = act_r.motor_fast;
    assign fill_valve_on  = act_r.fill_valve_on;
    assign drain_valve_on = act_r.drain_valve_on;
    assign detergent_req  = act_r.detergent_req;
    assign done           = act_r.done;
    assign fault          = act_r.fault;
    assign busy           = act_r.busy;
    assign state_o        = state_r;
    assign rinse_left_o   = rinse_left_r;

endmodule

// File: tb/tb_iiitb_wm_ctrl.sv
// Self-checking bench for iiitb_wm_ctrl: a program-level reference model
// (remaining-tick counts, saved state, rinse count) checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_iiitb_wm_ctrl;
    import iiitb_wm_pkg::*;

    localparam int WT = 100, RT = 50, ST = 80, FT = 200, DT = 200;

    logic clk = 1'b0;
    logic reset_n, tick, start, door_closed, filled, detergent_added, drained;
    logic pause, abort, fault_clr;
    logic [1:0] mode, rinse_cnt;
    logic door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on, detergent_req;
    logic done, fault, busy;
    logic [3:0] state_o;
    logic [1:0] rinse_left_o;

    int n_checks = 0;
    int n_pass   = 0;
    int det_visits = 0;
    bit sense_rand = 1'b0;
    bit en_fill    = 1'b1;
    bit m_valid    = 1'b0;

    always #5 clk = ~clk;

    iiitb_wm_ctrl #(.TIMER_W(16), .WASH_TICKS(WT), .RINSE_TICKS(RT), .SPIN_TICKS(ST),
                    .FILL_TIMEOUT(FT), .DRAIN_TIMEOUT(DT), .RINSE_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .door_closed(door_closed),
        .mode(mode), .rinse_cnt(rinse_cnt), .filled(filled), .detergent_added(detergent_added),
        .drained(drained), .pause(pause), .abort(abort), .fault_clr(fault_clr),
        .door_lock(door_lock), .motor_on(motor_on), .motor_fast(motor_fast),
        .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .detergent_req(detergent_req), .done(done), .fault(fault), .busy(busy),
        .state_o(state_o), .rinse_left_o(rinse_left_o));

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  saved;
        logic        rph;   // in rinse phase
        logic        ab;    // program aborted
        logic [1:0]  md;
        logic [1:0]  rl;
        logic [31:0] rem;   // ticks left on the running timer
    } m_t;

    m_t m = '0;

    function automatic logic [31:0] agit_len(input m_t x);
        if (x.rph) return RT;
        else return WT * (2 ** x.md);
    endfunction

    function automatic m_t step(input m_t x, input logic rst_n, tk, st_i, dr_c,
                                input logic [1:0] md_i, rc_i,
                                input logic fl, dt, drn, pz, abt, fc);
        m_t n;
        bit active, engaged, exp;
        n = x;
        if (!rst_n) return '0;
        active  = x.st inside {ST_FILL, ST_DETERGENT, ST_AGITATE, ST_DRAIN, ST_SPIN};
        engaged = active || (x.st == ST_PAUSE);
        exp     = tk && (x.rem == 1);
        if (engaged && !dr_c) n.st = ST_FAULT;
        else if (engaged && abt) begin n.ab = 1'b1; n.st = ST_DRAIN; n.rem = DT; end
        else if (active && pz) begin n.saved = x.st; n.st = ST_PAUSE; end
        else begin
            if (active && tk && x.rem > 0) n.rem = x.rem - 1;
            case (x.st)
                ST_IDLE: if (st_i && dr_c) begin
                    n.md = md_i; n.rl = rc_i; n.rph = (md_i == 2'd3);
                    n.st = ST_FILL; n.rem = FT;
                end
                ST_FILL: if (exp) n.st = ST_FAULT;
                         else if (fl && !x.rph) n.st = ST_DETERGENT;
                         else if (fl) begin n.st = ST_AGITATE; n.rem = agit_len(x); end
                ST_DETERGENT: if (dt) begin n.st = ST_AGITATE; n.rem = agit_len(x); end
                ST_AGITATE: if (exp) begin n.st = ST_DRAIN; n.rem = DT; end
                ST_DRAIN: if (exp) n.st = ST_FAULT;
                          else if (drn && x.ab) n.st = ST_DONE;
                          else if (drn && x.rl > 0) begin
                              n.rl = x.rl - 2'd1; n.rph = 1'b1; n.st = ST_FILL; n.rem = FT;
                          end else if (drn) begin n.st = ST_SPIN; n.rem = ST; end
                ST_SPIN: if (exp) n.st = ST_DONE;
                ST_DONE: if (!st_i) n.st = ST_IDLE;
                ST_PAUSE: if (!pz) n.st = x.saved;
                ST_FAULT: if (fc) begin n.st = ST_IDLE; n.ab = 1'b0; n.rph = 1'b0; n.rl = 2'd0; end
                default: n.st = ST_FAULT;
            endcase
        end
        return n;
    endfunction

    // {door_lock, motor_on, motor_fast, fill, drain, detergent, done, fault, busy}
    function automatic logic [8:0] outs(input logic [3:0] s);
        case (s)
            ST_FILL:      return 9'b1_0_0_1_0_0_0_0_1;
            ST_DETERGENT: return 9'b1_0_0_0_0_1_0_0_1;
            ST_AGITATE:   return 9'b1_1_0_0_0_0_0_0_1;
            ST_DRAIN:     return 9'b1_0_0_0_1_0_0_0_1;
            ST_SPIN:      return 9'b1_1_1_0_1_0_0_0_1;
            ST_DONE:      return 9'b0_0_0_0_0_0_1_0_0;
            ST_PAUSE:     return 9'b1_0_0_0_0_0_0_0_1;
            ST_FAULT:     return 9'b1_0_0_0_0_0_0_1_0;
            default:      return 9'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        m <= step(m, reset_n, tick, start, door_closed, mode, rinse_cnt,
                  filled, detergent_added, drained, pause, abort, fault_clr);
        if (!reset_n) m_valid <= 1'b1;
    end

    // Per-cycle compare of every output against the model.
    logic [3:0] prev_st = 4'd0;
    always @(negedge clk) begin
        logic [14:0] act_v, exp_v;
        if (m_valid) begin
            act_v = {state_o, rinse_left_o, door_lock, motor_on, motor_fast, fill_valve_on,
                     drain_valve_on, detergent_req, done, fault, busy};
            exp_v = {m.st, m.rl, outs(m.st)};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL model_cmp t=%0t: got %h required %h", $time, act_v, exp_v);
            if (state_o == ST_DETERGENT && prev_st != ST_DETERGENT) det_visits++;
            prev_st = state_o;
        end
    end

    // Sensor responder: answers each request 2 cycles later, or random in soak.
    initial begin
        int fc = 0, dc = 0, rc = 0;
        filled = 1'b0; detergent_added = 1'b0; drained = 1'b0;
        forever begin
            @(negedge clk);
            if (sense_rand) begin
                filled          = ($urandom % 6) == 0;
                detergent_added = ($urandom % 4) == 0;
                drained         = ($urandom % 6) == 0;
            end else begin
                fc = fill_valve_on  ? fc + 1 : 0;
                dc = detergent_req  ? dc + 1 : 0;
                rc = drain_valve_on ? rc + 1 : 0;
                filled          = en_fill && (fc >= 2);
                detergent_added = (dc >= 2);
                drained         = (rc >= 2);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", nm, act, req);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget, input string nm);
        int k = 0;
        while (state_o !== code && k < budget) begin @(negedge clk); k++; end
        n_checks++;
        if (state_o === code) n_pass++;
        else $display("FAIL %s: state_o=%0d required %0d within %0d cycles", nm, state_o, code, budget);
    endtask

    task automatic run_len(input logic [3:0] code, input int budget, output int len);
        int k = 0;
        while (state_o === code && k < budget) begin @(negedge clk); k++; end
        len = k;
    endtask

    task automatic finish_prog();
        wait_state(ST_DONE, 2000, "reach_done");
        start = 1'b0;
        @(negedge clk);
        wait_state(ST_IDLE, 5, "back_idle");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len, bad, dv, saw_spin;
        reset_n = 1'b0; tick = 1'b1; start = 1'b0; door_closed = 1'b1;
        mode = 2'd0; rinse_cnt = 2'd0; pause = 1'b0; abort = 1'b0; fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_state", state_o, ST_IDLE);
        chk("reset_outs", {door_lock, motor_on, fill_valve_on, drain_valve_on, done, fault, busy}, 0);

        // quick wash, no rinse
        start = 1'b1;
        wait_state(ST_AGITATE, 50, "q_to_agitate");
        run_len(ST_AGITATE, 500, len);  chk("q_agitate_len", len, 100);
        chk("q_after_agitate", state_o, ST_DRAIN);
        wait_state(ST_SPIN, 20, "q_to_spin");
        run_len(ST_SPIN, 500, len);     chk("q_spin_len", len, 80);
        chk("q_done_state", state_o, ST_DONE);
        chk("q_done_flags", {done, door_lock}, 2'b10);
        start = 1'b0; @(negedge clk);
        wait_state(ST_IDLE, 5, "q_idle");

        // heavy wash, two rinses
        dv = det_visits;
        mode = 2'd2; rinse_cnt = 2'd2; start = 1'b1;
        wait_state(ST_FILL, 5, "h_fill");
        chk("h_rinse_left_2", rinse_left_o, 2);
        wait_state(ST_AGITATE, 50, "h_agitate");
        run_len(ST_AGITATE, 1000, len); chk("h_soap_len", len, 400);
        for (int r = 1; r >= 0; r--) begin
            wait_state(ST_FILL, 50, "h_rinse_fill");
            chk("h_rinse_left", rinse_left_o, r);
            wait_state(ST_AGITATE, 50, "h_rinse_agitate");
            run_len(ST_AGITATE, 500, len); chk("h_rinse_len", len, 50);
        end
        finish_prog();
        chk("h_detergent_visits", det_visits - dv, 1);

        // pause 30 ticks into agitate
        mode = 2'd0; rinse_cnt = 2'd0; start = 1'b1;
        wait_state(ST_AGITATE, 50, "p_agitate");
        repeat (30) @(negedge clk);
        pause = 1'b1; @(negedge clk);
        chk("p_paused", state_o, ST_PAUSE);
        bad = 0;
        repeat (499) begin @(negedge clk); if (motor_on !== 1'b0 || door_lock !== 1'b1) bad++; end
        chk("p_hold_outputs_bad", bad, 0);
        pause = 1'b0; @(negedge clk);
        chk("p_resumed", state_o, ST_AGITATE);
        run_len(ST_AGITATE, 500, len); chk("p_remaining", len, 70);
        finish_prog();

        // abort mid-spin
        start = 1'b1;
        wait_state(ST_SPIN, 400, "a_spin");
        repeat (20) @(negedge clk);
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        chk("a_drain", state_o, ST_DRAIN);
        saw_spin = 0;
        for (int k = 0; k < 20 && state_o !== ST_DONE; k++) begin
            @(negedge clk); if (state_o === ST_SPIN) saw_spin++;
        end
        chk("a_done", state_o, ST_DONE);
        chk("a_no_spin", saw_spin, 0);
        start = 1'b0; @(negedge clk);
        wait_state(ST_IDLE, 5, "a_idle");

        // fill watchdog
        en_fill = 1'b0; start = 1'b1;
        wait_state(ST_FILL, 5, "w_fill");
        run_len(ST_FILL, 400, len); chk("w_fill_len", len, 200);
        chk("w_fault", {state_o, fill_valve_on, fault}, {ST_FAULT, 2'b01});
        start = 1'b0; en_fill = 1'b1; fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        chk("w_cleared", state_o, ST_IDLE);

        // door opened during agitate
        start = 1'b1;
        wait_state(ST_AGITATE, 50, "d_agitate");
        repeat (5) @(negedge clk);
        door_closed = 1'b0; @(negedge clk);
        chk("d_fault", state_o, ST_FAULT);
        door_closed = 1'b1; start = 1'b0; fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        chk("d_cleared", state_o, ST_IDLE);

        // reset mid-program
        start = 1'b1;
        wait_state(ST_AGITATE, 50, "r_agitate");
        repeat (3) @(negedge clk);
        reset_n = 1'b0; @(negedge clk);
        chk("r_state", state_o, ST_IDLE);
        chk("r_outs", {door_lock, motor_on, motor_fast, fill_valve_on, drain_valve_on,
                       detergent_req, done, fault, busy}, 0);
        reset_n = 1'b1; start = 1'b0; @(negedge clk);

        // randomized soak, checked by the model every cycle
        sense_rand = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            tick        = ($urandom % 2) == 0;
            start       = ($urandom % 16) != 0;
            door_closed = ($urandom % 700) != 0;
            if (($urandom % 80) == 0) pause = ~pause;
            abort       = ($urandom % 400) == 0;
            fault_clr   = ($urandom % 30) == 0;
            mode        = 2'($urandom);
            rinse_cnt   = 2'($urandom);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
